mmu_decode: RTL and testbench
=============================

# mmu_decode

Read-path counterpart of the MMU write encoder: takes the four byte-lane words returned by the byte-banked memory, undoes the address-alignment lane rotation, selects and sign/zero-extends the loaded byte, half or word, and returns the result to the pipeline. It also owns the MMIO read path, with a request/response handshake, a stall output and a timeout. It sits between the memory banks / MMIO bus and register writeback, one stage behind the write encoder's address stage.

## Interface
Parameters:
- MMIO_ADDR_START_BIT, 31: address bit that selects MMIO when set.
- MMIO_TIMEOUT_CYCLES, 16: cycles to wait for `mmio_rvalid` before faulting; must be at least 1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  load request this cycle.
- `req_addr`  in  32  byte address, same value presented to the encoder.
- `req_size`  in  2  `mmu_pkg::load_size_e`: BYTE, HALF or WORD.
- `req_unsigned`  in  1  1 = zero-extend, 0 = sign-extend.
- `physical_data_out`  in  32  bank read data: lane n on bits [8n+7:8n]; valid the cycle after the address.
- `mmio_req`  out  1  one-cycle MMIO read strobe.
- `mmio_addr`  out  32  word address, with bits [1:0] forced to 0.
- `mmio_rdata`  in  32  MMIO read data.
- `mmio_rvalid`  in  1  MMIO response strobe.
- `busy`  out  1  requests are not accepted while high.
- `data_out`  out  32  extended load result.
- `data_valid`  out  1  `data_out` is valid for this cycle only.
- `load_fault`  out  1  MMIO timeout; asserted in the same cycle as `data_valid`.

## Operation
- Accept: a request is taken when `req_valid & ~busy`. Accepting captures the alignment (`addr[1:0]`), size, the unsigned flag and `is_mmio` into stage-1 registers.
- RAM path:
  - In stage 1, logical byte i is read from physical lane (i+align) mod 4. This is a rotate right by 8×align: align 1 → {p[7:0],p[31:8]}, align 2 → {p[15:0],p[31:16]}, align 3 → {p[23:0],p[31:24]}.
  - After the rotate, keep bits [7:0] for BYTE, [15:0] for HALF or [31:0] for WORD.
  - Extend from bit 7 or bit 15 unless `req_unsigned` is set.
  - Register the result into `data_out` and pulse `data_valid`.
  - Requests are fully pipelined, one per cycle.
- MMIO path:
  - `mmio_req` is pulsed and `mmio_addr` driven in the cycle after acceptance.
  - Wait for `mmio_rvalid`. `mmio_rdata` is lane-0 justified; `addr[1:0]` is ignored and no rotation is applied. Size and extension rules are the same as the RAM path.
- Reserved `req_size` value (2'b11): treated as WORD.
- FSM states:
  - IDLE: an MMIO accept moves to ISSUE. RAM accepts stay in IDLE.
  - ISSUE: assert `mmio_req`, load the timeout counter with MMIO_TIMEOUT_CYCLES−1, then go to WAIT.
  - WAIT:
    - `mmio_rvalid` registers the extended data, then go to IDLE.
    - Counter reaching 0 sets `data_out` = 0, pulses `load_fault`, then goes to IDLE.
    - Otherwise decrement the counter.
- `busy` = (state ≠ IDLE) and is combinational from state. The requester holds its request while `busy` is high.
- Boundary cases:
  - A RAM load in stage 1 when an MMIO load is accepted completes normally in the next cycle.
  - `mmio_rvalid` in the same cycle as counter = 0: the response wins and there is no fault.
  - `mmio_rvalid` outside WAIT is ignored.
  - Reset asserted mid-operation: the in-flight load is dropped with no `data_valid`, and the FSM returns to IDLE.

## Timing
- Reset values: `data_out` 0, `data_valid` 0, `load_fault` 0, `mmio_req` 0, `mmio_addr` 0, `busy` 0, state IDLE, stage-1 valid 0, counter 0.
- RAM latency: accept at cycle N; bank data arrives in N+1; `data_valid` is high in N+2.
- MMIO timing: `mmio_req` is high in N+1. If `mmio_rvalid` arrives in cycle M, `data_valid` is high in M+1 and `busy` is low in M+1.
- Timeout timing: with no response, the fault result has `data_valid` high in N+2+MMIO_TIMEOUT_CYCLES.
- All outputs except `busy` are registered.

## Structure
- `mmu_pkg` holds:
  - `load_size_e` (BYTE = 0, HALF = 1, WORD = 2);
  - the `mmio_state_e` enum (IDLE, ISSUE, WAIT);
  - an `mmu_pkg::extend` function shared with future store-forwarding logic.
- Sub-module `mmu_load_align`: combinational rotate, select and extend, taking align, size, unsigned and data; it is instantiated once.
- The FSM, the stage-1 registers and the output registers live in `mmu_decode`.

## Test plan
- Aligned word: addr 0x100, WORD, `physical_data_out`=0xDEADBEEF → `data_out` 0xDEADBEEF, `data_valid` high at N+2.
- Misaligned signed half: addr 0x103, HALF, p=0x80AABBCC → 0xFFFFCC80. With `req_unsigned` set → 0x0000CC80.
- Bytes back to back: addr 0x102 BYTE signed, then unsigned, on consecutive cycles with p=0x00F50000 → 0xFFFFFFF5 then 0x000000F5, with `data_valid` high two consecutive cycles.
- MMIO: addr 0x8000_0006, WORD; `mmio_rvalid` 3 cycles after `mmio_req` with 0x12345678 → `mmio_addr` 0x8000_0004, `busy` high 4 cycles, `data_out` 0x12345678.
- Timeout: MMIO load with no response and MMIO_TIMEOUT_CYCLES=4 → `load_fault` and `data_valid` high at N+6, `data_out` 0. Also `mmio_rvalid` exactly at counter 0 → no fault.
- Reset in WAIT: deassert `rst_n` for 1 cycle → `busy` drops immediately and no `data_valid` is produced. A new RAM load after reset completes normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and helpers for the MMU load path.
// Size encoding and the extend helper are reused by store forwarding.
package mmu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } load_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mmio_state_e;

    // Any size other than BYTE/HALF (including the reserved code) is a word.
    function automatic logic [31:0] extend(
        input logic [31:0] d,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [31:0] r;
        r = d;
        if (sz == 2'(BYTE)) begin
            r = {{24{~uns & d[7]}}, d[7:0]};
        end else if (sz == 2'(HALF)) begin
            r = {{16{~uns & d[15]}}, d[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/mmu_load_align.sv
// Undoes the bank lane rotation, then selects and extends the load.
// Purely combinational.
module mmu_load_align
    import mmu_pkg::*;
(
    input  logic [1:0]  i_align,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [31:0] w_rot;

    always_comb begin
        w_rot = i_data;
        unique case (i_align)
            2'd0: w_rot = i_data;
            2'd1: w_rot = {i_data[7:0], i_data[31:8]};
            2'd2: w_rot = {i_data[15:0], i_data[31:16]};
            2'd3: w_rot = {i_data[23:0], i_data[31:24]};
        endcase
    end

    assign o_data = extend(w_rot, i_size, i_unsigned);

endmodule

// File: rtl/mmu_decode.sv
// MMU load decoder: RAM lane un-rotation plus the MMIO read path
// with request strobe, busy stall and response timeout.
module mmu_decode
    import mmu_pkg::*;
#(
    parameter int MMIO_ADDR_START_BIT = 31,
    parameter int MMIO_TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] physical_data_out,
    output logic        mmio_req,
    output logic [31:0] mmio_addr,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_rvalid,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        load_fault
);

    localparam int CW = $clog2(MMIO_TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MMIO_TIMEOUT_CYCLES - 1);

    mmio_state_e r_state;
    logic [CW-1:0] r_cnt;

    logic        r_s1_valid;
    logic        r_s1_mmio;
    logic        r_s1_unsigned;
    logic [1:0]  r_s1_align;
    logic [1:0]  r_s1_size;

    logic        r_mmio_req;
    logic [31:0] r_mmio_addr;
    logic [31:0] r_data_out;
    logic        r_data_valid;
    logic        r_load_fault;

    logic        w_accept;
    logic        w_is_mmio;
    logic        w_in_wait;
    logic        w_ram_done;
    logic        w_mmio_done;
    logic        w_timeout;
    logic [1:0]  w_align;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    assign busy        = (r_state != IDLE);
    assign w_accept    = req_valid & ~busy;
    assign w_is_mmio   = req_addr[MMIO_ADDR_START_BIT];
    assign w_in_wait   = (r_state == WAIT);
    assign w_ram_done  = r_s1_valid & ~r_s1_mmio;
    assign w_mmio_done = w_in_wait & mmio_rvalid;
    assign w_timeout   = w_in_wait & ~mmio_rvalid & (r_cnt == '0);

    // While waiting no RAM load can be in stage 1, so the aligner is free.
    assign w_align = w_in_wait ? 2'b00 : r_s1_align;
    assign w_raw   = w_in_wait ? mmio_rdata : physical_data_out;

    mmu_load_align u_align (
        .i_align    (w_align),
        .i_size     (r_s1_size),
        .i_unsigned (r_s1_unsigned),
        .i_data     (w_raw),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_mmio     <= 1'b0;
            r_s1_unsigned <= 1'b0;
            r_s1_align    <= 2'b00;
            r_s1_size     <= 2'b00;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mmio     <= w_is_mmio;
                r_s1_unsigned <= req_unsigned;
                r_s1_align    <= req_addr[1:0];
                r_s1_size     <= req_size;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mmio_req  <= 1'b0;
            r_mmio_addr <= '0;
        end else begin
            r_mmio_req <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_is_mmio) begin
                        r_state     <= ISSUE;
                        r_mmio_req  <= 1'b1;
                        r_mmio_addr <= {req_addr[31:2], 2'b00};
                    end
                end
                ISSUE: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mmio_rvalid || r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_load_fault <= 1'b0;
        end else begin
            r_data_valid <= w_ram_done | w_mmio_done | w_timeout;
            r_load_fault <= w_timeout;
            if (w_timeout) begin
                r_data_out <= '0;
            end else if (w_ram_done || w_mmio_done) begin
                r_data_out <= w_ext;
            end
        end
    end

    assign mmio_req   = r_mmio_req;
    assign mmio_addr  = r_mmio_addr;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign load_fault = r_load_fault;

endmodule

// File: tb/tb_mmu_decode.sv
// Directed bench for mmu_decode: RAM vector table plus MMIO,
// timeout and reset sequences.
module tb_mmu_decode;
    import mmu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] physical_data_out = '0;
    logic        mmio_req;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_rdata = '0;
    logic        mmio_rvalid = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        load_fault;

    int checks = 0;
    int failures = 0;

    mmu_decode #(
        .MMIO_ADDR_START_BIT (31),
        .MMIO_TIMEOUT_CYCLES (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .physical_data_out (physical_data_out),
        .mmio_req          (mmio_req),
        .mmio_addr         (mmio_addr),
        .mmio_rdata        (mmio_rdata),
        .mmio_rvalid       (mmio_rvalid),
        .busy              (busy),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .load_fault        (load_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] pdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_start(input logic [31:0] a, input logic [1:0] sz,
                              input logic u);
        req_valid = 1'b1;
        req_addr = a;
        req_size = sz;
        req_unsigned = u;
        step();
        req_valid = 1'b0;
    endtask

    int nbusy;

    initial begin
        vecs[0] = '{32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{32'h103, 2'd1, 1'b0, 32'h80AABBCC, 32'hFFFFCC80};
        vecs[2] = '{32'h103, 2'd1, 1'b1, 32'h80AABBCC, 32'h0000CC80};
        vecs[3] = '{32'h102, 2'd0, 1'b0, 32'h00F50000, 32'hFFFFFFF5};
        vecs[4] = '{32'h101, 2'd0, 1'b1, 32'h11223344, 32'h00000033};
        vecs[5] = '{32'h101, 2'd1, 1'b0, 32'h11A23344, 32'hFFFFA233};
        vecs[6] = '{32'h002, 2'd2, 1'b0, 32'h11223344, 32'h33441122};
        vecs[7] = '{32'h000, 2'd3, 1'b0, 32'h8000007F, 32'h8000007F};
        vecs[8] = '{32'h000, 2'd0, 1'b0, 32'h1234567F, 32'h0000007F};
        vecs[9] = '{32'h000, 2'd1, 1'b1, 32'hFFFF8001, 32'h00008001};

        #2;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_data_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_load_fault", {31'b0, load_fault}, 32'h0);
        chk("rst_mmio_req", {31'b0, mmio_req}, 32'h0);
        chk("rst_mmio_addr", mmio_addr, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_addr = vecs[i].addr;
            req_size = vecs[i].size;
            req_unsigned = vecs[i].uns;
            step();
            req_valid = 1'b0;
            physical_data_out = vecs[i].pdata;
            chk($sformatf("vec%0d_dv_n1", i), {31'b0, data_valid}, 32'h0);
            step();
            physical_data_out = '0;
            chk($sformatf("vec%0d_dv", i), {31'b0, data_valid}, 32'h1);
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
        end
        step();

        // Back-to-back byte loads
        req_valid = 1'b1;
        req_addr = 32'h102;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        step();
        req_unsigned = 1'b1;
        physical_data_out = 32'h00F50000;
        step();
        req_valid = 1'b0;
        chk("b2b_dv0", {31'b0, data_valid}, 32'h1);
        chk("b2b_data0", data_out, 32'hFFFFFFF5);
        step();
        physical_data_out = '0;
        chk("b2b_dv1", {31'b0, data_valid}, 32'h1);
        chk("b2b_data1", data_out, 32'h000000F5);
        step();
        chk("b2b_dv_end", {31'b0, data_valid}, 32'h0);

        // MMIO word, response 3 cycles after the strobe
        chk("mmio_busy_pre", {31'b0, busy}, 32'h0);
        mmio_start(32'h80000006, 2'd2, 1'b0);
        nbusy = 0;
        chk("mmio_req_n1", {31'b0, mmio_req}, 32'h1);
        chk("mmio_addr", mmio_addr, 32'h80000004);
        for (int c = 0; c < 3; c++) begin
            if (busy) nbusy++;
            step();
        end
        chk("mmio_req_n4", {31'b0, mmio_req}, 32'h0);
        if (busy) nbusy++;
        mmio_rvalid = 1'b1;
        mmio_rdata = 32'h12345678;
        step();
        mmio_rvalid = 1'b0;
        mmio_rdata = '0;
        if (busy) nbusy++;
        chk("mmio_busy_cycles", nbusy, 32'd4);
        chk("mmio_dv", {31'b0, data_valid}, 32'h1);
        chk("mmio_data", data_out, 32'h12345678);
        chk("mmio_nofault", {31'b0, load_fault}, 32'h0);
        step();

        // MMIO half, no lane rotation applied
        mmio_start(32'h80000003, 2'd1, 1'b0);
        step();
        mmio_rvalid = 1'b1;
        mmio_rdata = 32'h00009ABC;
        step();
        mmio_rvalid = 1'b0;
        chk("mmio_half", data_out, 32'hFFFF9ABC);
        chk("mmio_half_dv", {31'b0, data_valid}, 32'h1);
        step();

        // RAM load in stage 1 while an MMIO load is accepted
        req_valid = 1'b1;
        req_addr = 32'h200;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        step();
        req_addr = 32'h80000010;
        physical_data_out = 32'hA5A5A5A5;
        step();
        req_valid = 1'b0;
        physical_data_out = '0;
        chk("overlap_ram_dv", {31'b0, data_valid}, 32'h1);
        chk("overlap_ram_data", data_out, 32'hA5A5A5A5);
        chk("overlap_mmio_req", {31'b0, mmio_req}, 32'h1);
        step();
        mmio_rvalid = 1'b1;
        mmio_rdata = 32'h0BADF00D;
        step();
        mmio_rvalid = 1'b0;
        chk("overlap_mmio_data", data_out, 32'h0BADF00D);
        step();

        // Timeout with no response
        mmio_start(32'h80000020, 2'd2, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("to_dv_n%0d", c), {31'b0, data_valid}, 32'h0);
            step();
        end
        chk("to_dv", {31'b0, data_valid}, 32'h1);
        chk("to_fault", {31'b0, load_fault}, 32'h1);
        chk("to_data", data_out, 32'h0);
        chk("to_busy", {31'b0, busy}, 32'h0);
        step();
        chk("to_fault_end", {31'b0, load_fault}, 32'h0);

        // Response at counter 0; a stray strobe in ISSUE is ignored
        mmio_start(32'h80000030, 2'd2, 1'b0);
        mmio_rvalid = 1'b1;
        mmio_rdata = 32'hFFFFFFFF;
        step();
        mmio_rvalid = 1'b0;
        chk("issue_rvalid_ign", {31'b0, data_valid}, 32'h0);
        step();
        step();
        step();
        mmio_rvalid = 1'b1;
        mmio_rdata = 32'hCAFEF00D;
        step();
        mmio_rvalid = 1'b0;
        chk("cnt0_dv", {31'b0, data_valid}, 32'h1);
        chk("cnt0_nofault", {31'b0, load_fault}, 32'h0);
        chk("cnt0_data", data_out, 32'hCAFEF00D);

        // Stray strobe in IDLE is ignored
        mmio_rvalid = 1'b1;
        step();
        mmio_rvalid = 1'b0;
        chk("idle_rvalid_ign", {31'b0, data_valid}, 32'h0);

        // Reset while waiting on MMIO
        mmio_start(32'h80000040, 2'd2, 1'b0);
        step();
        chk("rw_busy_pre", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy_rst", {31'b0, busy}, 32'h0);
        step();
        rst_n = 1'b1;
        nbusy = 0;
        for (int c = 0; c < 6; c++) begin
            if (data_valid) nbusy++;
            if (c == 2) mmio_rvalid = 1'b1;
            step();
            mmio_rvalid = 1'b0;
        end
        chk("rw_no_dv", nbusy, 32'd0);
        req_valid = 1'b1;
        req_addr = 32'h301;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        step();
        req_valid = 1'b0;
        physical_data_out = 32'h44332211;
        step();
        chk("rw_ram_dv", {31'b0, data_valid}, 32'h1);
        chk("rw_ram_data", data_out, 32'h11443322);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
